// File: rtl/stopwatch_debounce_pkg.sv
// Shared constants for the stopwatch button conditioner: clock rate,
// derived timing defaults and button channel indices.
package stopwatch_pkg;
  localparam int CLK_HZ   = 50_000_000;
  localparam int DBN_10MS = CLK_HZ / 100;
  localparam int LPN_2S   = CLK_HZ * 2;
  localparam int DW_DEF   = 20;
  localparam int LW_DEF   = 27;
  localparam int BTN_RUN  = 0;
  localparam int BTN_CLR  = 1;
endpackage

// File: rtl/stopwatch_debounce_if.sv
// Button bundle: raw level in, debounced level and strobes out.
// o_lng-side signal exists only with STOPWATCH_DEBOUNCE_LONG_EN.
interface stopwatch_debounce_if #(parameter int W = 1);
  logic [W-1:0] btn;
  logic [W-1:0] lvl;
  logic [W-1:0] prs;
  logic [W-1:0] rel;
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
  logic [W-1:0] lng;
  modport master (output btn, input lvl, prs, rel, lng);
  modport slave  (input btn, output lvl, prs, rel, lng);
`else
  modport master (output btn, input lvl, prs, rel);
  modport slave  (input btn, output lvl, prs, rel);
`endif
endinterface

// File: rtl/stopwatch_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce counter, press/release
// strobes and, with STOPWATCH_DEBOUNCE_LONG_EN, the long-press strobe.
module stopwatch_debounce_ch
  import stopwatch_pkg::*;
#(
  parameter int DBN = DBN_10MS,
  parameter int DW  = DW_DEF
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
  , parameter int LPN = LPN_2S
  , parameter int LW  = LW_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_debounce_if.slave  b
);
  logic          r_s1, r_s2, r_lvl, r_prs, r_rel;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_nxt;
  logic          w_lvl_nxt;

  // Count consecutive disagreeing samples; any agreement restarts the window.
  always_comb begin
    w_lvl_nxt = r_lvl;
    w_cnt_nxt = '0;
    if (r_s2 != r_lvl) begin
      if (r_cnt == DW'(DBN - 1)) w_lvl_nxt = r_s2;
      else                       w_cnt_nxt = r_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      r_lvl <= 1'b0;
      r_prs <= 1'b0;
      r_rel <= 1'b0;
    end else begin
      r_s1  <= b.btn[0];
      r_s2  <= r_s1;
      r_cnt <= w_cnt_nxt;
      r_lvl <= w_lvl_nxt;
      r_prs <= w_lvl_nxt & ~r_lvl;
      r_rel <= ~w_lvl_nxt & r_lvl;
    end
  end

  assign b.lvl[0] = r_lvl;
  assign b.prs[0] = r_prs;
  assign b.rel[0] = r_rel;

`ifdef STOPWATCH_DEBOUNCE_LONG_EN
  logic [LW-1:0] r_lcnt;
  logic          r_lng;

  // Counter parks at LPN-1 so the strobe fires once per hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lcnt <= '0;
      r_lng  <= 1'b0;
    end else if (!r_lvl) begin
      r_lcnt <= '0;
      r_lng  <= 1'b0;
    end else if (r_lcnt != LW'(LPN - 1)) begin
      r_lcnt <= r_lcnt + LW'(1);
      r_lng  <= (r_lcnt == LW'(LPN - 2));
    end else begin
      r_lng  <= 1'b0;
    end
  end

  assign b.lng[0] = r_lng;
`endif
endmodule

// File: rtl/stopwatch_debounce.sv
// Button conditioner ahead of the stopwatch core: BN independent debounce
// channels. Long-press strobe o_lng present only with STOPWATCH_DEBOUNCE_LONG_EN.
module stopwatch_debounce
  import stopwatch_pkg::*;
#(
  parameter int BN  = 2,
  parameter int DBN = DBN_10MS,
  parameter int DW  = DW_DEF
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
  , parameter int LPN = LPN_2S
  , parameter int LW  = LW_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BN-1:0] i_btn,
  output wire  [BN-1:0] o_lvl,
  output wire  [BN-1:0] o_prs,
  output wire  [BN-1:0] o_rel
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
  , output wire [BN-1:0] o_lng
`endif
);
  for (genvar g = 0; g < BN; g++) begin : g_ch
    stopwatch_debounce_if #(.W(1)) ch_if ();

    assign ch_if.btn[0] = i_btn[g];
    assign o_lvl[g]     = ch_if.lvl[0];
    assign o_prs[g]     = ch_if.prs[0];
    assign o_rel[g]     = ch_if.rel[0];
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
    assign o_lng[g]     = ch_if.lng[0];
`endif

    stopwatch_debounce_ch #(
      .DBN (DBN),
      .DW  (DW)
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
      , .LPN (LPN)
      , .LW  (LW)
`endif
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .b   (ch_if.slave)
    );
  end
endmodule

// File: tb/tb_stopwatch_debounce.sv
// Directed + random bench for stopwatch_debounce against a sample-window model.
module tb_stopwatch_debounce;
  localparam int BN  = 2;
  localparam int DBN = 4;
  localparam int DW  = 4;
  localparam int LPN = 20;
  localparam int LW  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  string phase = "init";

  stopwatch_debounce_if #(.W(BN)) bus ();

  stopwatch_debounce #(
    .BN(BN), .DBN(DBN), .DW(DW)
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
    , .LPN(LPN), .LW(LW)
`endif
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .i_btn (bus.btn),
    .o_lvl (bus.lvl),
    .o_prs (bus.prs),
    .o_rel (bus.rel)
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
    , .o_lng (bus.lng)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a channel flips when the synchronized input (raw input two
  // edges back) has differed from the current level on DBN straight edges.
  logic [BN-1:0] hist[$];
  logic [BN-1:0] m_lvl, m_prs, m_rel, m_lng;
  int            held[BN];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
      for (int i = 0; i < DBN + 2; i++) hist.push_back('0);
      m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0;
      for (int c = 0; c < BN; c++) held[c] = 0;
    end else begin
      hist.push_back(bus.btn);
      if (hist.size() > 64) void'(hist.pop_front());
      for (int c = 0; c < BN; c++) begin
        bit flip;
        m_lng[c] = 1'b0;
        if (m_lvl[c]) begin
          held[c]++;
          if (held[c] == LPN - 1) m_lng[c] = 1'b1;
        end else held[c] = 0;
        flip = 1'b1;
        for (int j = 0; j < DBN; j++) begin
          logic [BN-1:0] v;
          v = hist[hist.size() - 3 - j];
          if (v[c] == m_lvl[c]) flip = 1'b0;
        end
        m_prs[c] = 1'b0;
        m_rel[c] = 1'b0;
        if (flip) begin
          m_lvl[c] = ~m_lvl[c];
          m_prs[c] = m_lvl[c];
          m_rel[c] = ~m_lvl[c];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [BN-1:0] got, input logic [BN-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s/%s got=%b exp=%b", phase, tag, got, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s/%s got=%0d exp=%0d", phase, tag, got, exp);
    end
  endtask

  int prs0_n, lng1_n, lng1_at;
  bit both_seen;

  task automatic tick();
    @(negedge clk);
    chk("lvl", bus.lvl, m_lvl);
    chk("prs", bus.prs, m_prs);
    chk("rel", bus.rel, m_rel);
`ifdef STOPWATCH_DEBOUNCE_LONG_EN
    chk("lng", bus.lng, m_lng);
    if (bus.lng[1]) lng1_n++;
`endif
    total++;
    assert ((bus.prs & bus.rel) === '0) else begin
      bad++;
      $error("FAIL %s/excl got=%b exp=00", phase, bus.prs & bus.rel);
    end
    if (bus.prs[0]) prs0_n++;
    if (bus.prs === 2'b11) both_seen = 1'b1;
  endtask

  // Ticks until bit c of o_lvl equals v; returns count (bounded).
  task automatic wait_lvl(input int c, input logic v, output int n);
    n = 0;
    do begin tick(); n++; end while (bus.lvl[c] !== v && n < 40);
  endtask

  initial begin
    int n;
    bus.btn = 2'b11;
    #1 rst = 1'b0;

    phase = "reset";
    repeat (5) tick();
    chk("lvl0", bus.lvl, 2'b00);
    chk("prs0", bus.prs, 2'b00);
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.lvl !== 2'b11 && n < 40);
    chk_i("lat", n, DBN + 2);
    chk("prs_at_rise", bus.prs, 2'b11);
    tick();
    chk("prs_one", bus.prs, 2'b00);

    phase = "clean";
    bus.btn = 2'b00;
    repeat (10) tick();
    bus.btn[0] = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk_i("rise_lat", n, DBN + 2);
    repeat (5) tick();
    bus.btn[0] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.rel[0] !== 1'b1 && n < 40);
    chk_i("rel_lat", n, DBN + 2);
    tick();
    chk("rel_one", bus.rel, 2'b00);

    phase = "bounce";
    repeat (6) tick();
    prs0_n = 0;
    for (int s = 0; s < 8; s++) begin
      bus.btn[0] = (s % 2 == 0);
      repeat (3) tick();
    end
    chk("lvl_held", bus.lvl, 2'b00);
    chk_i("prs_none", prs0_n, 0);
    bus.btn[0] = 1'b1;
    repeat (12) tick();
    chk_i("prs_single", prs0_n, 1);
    bus.btn = 2'b00;
    repeat (10) tick();

    phase = "simul";
    both_seen = 1'b0;
    bus.btn = 2'b11;
    repeat (10) tick();
    chk_i("both_prs", int'(both_seen), 1);
    bus.btn = 2'b00;
    repeat (10) tick();
    bus.btn[0] = 1'b1;
    n = 0;
    do begin
      if (n % 2 == 0) bus.btn[1] = ~bus.btn[1];
      tick(); n++;
    end while (bus.lvl[0] !== 1'b1 && n < 40);
    chk_i("ch0_indep", n, DBN + 2);
    chk_i("ch1_quiet", int'(bus.lvl[1]), 0);
    bus.btn = 2'b00;
    repeat (10) tick();

    phase = "rst_mid";
    bus.btn[0] = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("lvl_in_rst", bus.lvl, 2'b00);
    rst = 1'b1;
    wait_lvl(0, 1'b1, n);
    chk_i("rise_after_rst", n, DBN + 2);
    bus.btn = 2'b00;
    repeat (10) tick();

`ifdef STOPWATCH_DEBOUNCE_LONG_EN
    phase = "long";
    bus.btn[1] = 1'b1;
    wait_lvl(1, 1'b1, n);
    lng1_n = 0; lng1_at = -1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (bus.lng[1] && lng1_at < 0) lng1_at = j;
    end
    chk_i("lng_cnt", lng1_n, 1);
    chk_i("lng_at", lng1_at, LPN - 1);
    bus.btn = 2'b00;
    repeat (10) tick();
`endif

    phase = "random";
    for (int r = 0; r < 80; r++) begin
      bus.btn = BN'($urandom_range(0, 3));
      repeat ($urandom_range(1, 8)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
